// File: rtl/iterative_divider.sv
// iterative_divider: 32-bit restoring divider, one quotient bit per cycle; DIV_SIGNED_EN selects signed operands
module iterative_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic [WIDTH-1:0] data_remainder,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH:0] rem_q, rem_d, shift_rem, trial, rem_nx;
   logic [WIDTH-1:0] quot_q, quot_d, div_q, div_d, res_q, res_d, remo_q, remo_d;
   logic [WIDTH-1:0] mag_a, mag_b, q_nx, q_fix, r_fix;
   logic exc_q, exc_d, last, ge, b_zero;
`ifdef DIV_SIGNED_EN
   logic neg_q, neg_d, sa_q, sa_d;
`endif
   // operand magnitudes, trial subtraction and final sign fix-up
   always_comb begin
`ifdef DIV_SIGNED_EN
      mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
      mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
`else
      mag_a = data_operandA;
      mag_b = data_operandB;
`endif
      b_zero    = data_operandB == '0;
      last      = cnt_q == CNT_W'(WIDTH - 1);
      shift_rem = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
      ge        = rem_q[WIDTH] | (shift_rem >= {1'b0, div_q});
      trial     = shift_rem - {1'b0, div_q};
      rem_nx    = ge ? trial : shift_rem;
      q_nx      = {quot_q[WIDTH-2:0], ge};
`ifdef DIV_SIGNED_EN
      q_fix = neg_q ? -q_nx : q_nx;
      r_fix = sa_q ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
`else
      q_fix = q_nx;
      r_fix = rem_nx[WIDTH-1:0];
`endif
   end
   // next state: a start always restarts, even mid-operation
   always_comb begin
      state_d = state_q;
      if (ctrl_DIV)
         state_d = b_zero ? DONE : RUN;
      else if (state_q == RUN && last)
         state_d = DONE;
      else if (state_q == DONE)
         state_d = IDLE;
   end
   // datapath next values: latch on start, iterate in RUN, publish results on entry to DONE
   always_comb begin
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      quot_d = quot_q;
      div_d  = div_q;
      res_d  = res_q;
      remo_d = remo_q;
      exc_d  = exc_q;
`ifdef DIV_SIGNED_EN
      neg_d = neg_q;
      sa_d  = sa_q;
`endif
      if (ctrl_DIV) begin
         cnt_d  = '0;
         rem_d  = '0;
         quot_d = mag_a;
         div_d  = mag_b;
`ifdef DIV_SIGNED_EN
         neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         sa_d  = data_operandA[WIDTH-1];
`endif
         if (b_zero) begin
            res_d  = '0;
            remo_d = data_operandA;
            exc_d  = 1'b1;
         end
      end else if (state_q == RUN) begin
         cnt_d  = cnt_q + 1'b1;
         rem_d  = rem_nx;
         quot_d = q_nx;
         if (last) begin
            res_d  = q_fix;
            remo_d = r_fix;
            exc_d  = 1'b0;
         end
      end
   end
   // state register
   always_ff @(posedge clock) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end
   // datapath registers
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q  <= '0;
         rem_q  <= '0;
         quot_q <= '0;
         div_q  <= '0;
         res_q  <= '0;
         remo_q <= '0;
         exc_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
         neg_q <= 1'b0;
         sa_q  <= 1'b0;
`endif
      end else begin
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         quot_q <= quot_d;
         div_q  <= div_d;
         res_q  <= res_d;
         remo_q <= remo_d;
         exc_q  <= exc_d;
`ifdef DIV_SIGNED_EN
         neg_q <= neg_d;
         sa_q  <= sa_d;
`endif
      end
   end
   // outputs decoded from state and held result registers
   always_comb begin
      data_resultRDY = state_q == DONE;
      busy           = state_q != IDLE;
      data_result    = res_q;
      data_remainder = remo_q;
      data_exception = exc_q;
   end
endmodule

// File: tb/tb_iterative_divider.sv
// tb_iterative_divider: randomized self-checking bench for iterative_divider against an arithmetic model
module tb_iterative_divider;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [31:0] data_result, data_remainder;
   logic        data_exception, data_resultRDY, busy;
   int          n_tests = 0;
   int          n_fail = 0;

   iterative_divider dut (
      .clock(clock), .reset(reset), .ctrl_DIV(ctrl_DIV),
      .data_operandA(op_a), .data_operandB(op_b),
      .data_result(data_result), .data_remainder(data_remainder),
      .data_exception(data_exception), .data_resultRDY(data_resultRDY), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r, output logic e);
      longint sa, sb, sq, sr;
      if (b == 0) begin
         q = 0; r = a; e = 1'b1;
      end else begin
         e = 1'b0;
`ifdef DIV_SIGNED_EN
         sa = longint'($signed(a));
         sb = longint'($signed(b));
`else
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
`endif
         sq = sa / sb;
         sr = sa % sb;
         q = sq[31:0];
         r = sr[31:0];
      end
   endfunction

   task automatic start(input logic [31:0] a, input logic [31:0] b);
      ctrl_DIV = 1'b1; op_a = a; op_b = b;
      @(negedge clock);
      ctrl_DIV = 1'b0; op_a = $urandom; op_b = $urandom;
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit b2b);
      logic [31:0] eq, er;
      logic ee;
      int lat;
      model(a, b, eq, er, ee);
      start(a, b);
      lat = 1;
      if (b != 0) check("busy_run", busy, 1);
      while (!data_resultRDY && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      check("latency", lat, (b == 0) ? 1 : 33);
      check("quot", data_result, eq);
      check("rem", data_remainder, er);
      check("exc", data_exception, ee);
      check("busy_done", busy, 1);
      if (!b2b) begin
         @(negedge clock);
         check("rdy_pulse", data_resultRDY, 0);
         check("busy_idle", busy, 0);
         check("held_quot", data_result, eq);
         check("held_exc", data_exception, ee);
      end
   endtask

   initial begin
      bit saw;
      logic [31:0] ra, rb;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("rst_quot", data_result, 0);
      check("rst_rem", data_remainder, 0);
      check("rst_rdy", data_resultRDY, 0);
      check("rst_busy", busy, 0);
      check("rst_exc", data_exception, 0);

      run_op(100, 7, 0);
      check("q_100_7", data_result, 14);
      check("r_100_7", data_remainder, 2);

      run_op(32'hFFFF_FFFF, 0, 0);
      check("dz_quot", data_result, 0);
      check("dz_rem", data_remainder, 32'hFFFF_FFFF);
      check("dz_exc", data_exception, 1);
      run_op(9, 3, 0);
      check("q_9_3", data_result, 3);
      check("r_9_3", data_remainder, 0);
      check("exc_clear", data_exception, 0);

      start(1000, 10);
      saw = 0;
      repeat (9) begin
         if (data_resultRDY) saw = 1;
         @(negedge clock);
      end
      check("abort_nordy", saw, 0);
      check("abort_held", data_result, 3);
      run_op(50, 8, 0);
      check("q_50_8", data_result, 6);
      check("r_50_8", data_remainder, 2);

      start(12345, 6);
      repeat (19) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("mid_rst_quot", data_result, 0);
      check("mid_rst_rem", data_remainder, 0);
      check("mid_rst_rdy", data_resultRDY, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_exc", data_exception, 0);
      saw = 0;
      repeat (40) begin
         @(negedge clock);
         if (data_resultRDY) saw = 1;
      end
      check("mid_rst_nordy", saw, 0);

`ifdef DIV_SIGNED_EN
      run_op(32'hFFFF_FFF9, 2, 0);
      check("s_quot", data_result, 32'hFFFF_FFFD);
      check("s_rem", data_remainder, 32'hFFFF_FFFF);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
      check("ovf_quot", data_result, 32'h8000_0000);
      check("ovf_rem", data_remainder, 0);
      check("ovf_exc", data_exception, 0);
`else
      run_op(32'hFFFF_FFF9, 2, 0);
      check("u_quot", data_result, 32'h7FFF_FFFC);
      check("u_rem", data_remainder, 1);
`endif

      for (int i = 0; i < 30; i++) begin
         int sel;
         sel = $urandom_range(0, 7);
         ra = $urandom;
         rb = (sel == 0) ? 32'd0 : (sel < 3) ? 32'($urandom_range(1, 15)) : ($urandom >> $urandom_range(0, 31));
         run_op(ra, rb, bit'($urandom_range(0, 1)));
      end
      @(negedge clock);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
